apb_irq_ctrl: RTL and testbench



---
 rtl/apb_irq_ctrl_pkg.sv | 20 ++
 rtl/apb_irq_ctrl_prio_enc.sv | 20 ++
 rtl/apb_irq_ctrl.sv | 115 +++++++++++
 tb/tb_apb_irq_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared register indices, vector type and helpers for the APB interrupt collector.
package apb_irq_ctrl_pkg;

   typedef logic [31:0] irq_vec_t;

   localparam logic [2:0] REG_IER = 3'd0;
   localparam logic [2:0] REG_IPR = 3'd1;
   localparam logic [2:0] REG_ICP = 3'd2;
   localparam logic [2:0] REG_ISP = 3'd3;
   localparam logic [2:0] REG_ISR = 3'd4;

   // Bits at or above the number of implemented sources are forced to zero.
   function automatic irq_vec_t valid_mask(input int n);
      irq_vec_t m;
      if (n >= 32) m = '1;
      else         m = (irq_vec_t'(1) << n) - irq_vec_t'(1);
      return m;
   endfunction

endpackage

// File: rtl/apb_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of i_req and whether any bit is set.
module irq_prio_enc #(
   parameter int WIDTH = 32,
   parameter int ID_W  = 5
) (
   input  logic [WIDTH-1:0] i_req,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_id
);

   always_comb begin
      o_valid = |i_req;
      o_id    = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (i_req[k]) o_id = ID_W'(k);
      end
   end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt collector: per-line edge detect, pending latch and enable mask,
// fixed-priority request with id to the core and an ack handshake that clears one line.
module apb_irq_ctrl
   import apb_irq_ctrl_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int NUM_IRQ        = 32,
   parameter int ID_WIDTH       = 5
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   input  logic [NUM_IRQ-1:0]        irq_i,
   output logic                      irq_o,
   output logic [ID_WIDTH-1:0]       irq_id_o,
   input  logic                      irq_ack_i,
   input  logic [ID_WIDTH-1:0]       irq_ack_id_i
);

   localparam irq_vec_t VALID = valid_mask(NUM_IRQ);

   irq_vec_t            r_irq_q;
   irq_vec_t            r_ier;
   irq_vec_t            r_ipr;
   logic                r_irq;
   logic [ID_WIDTH-1:0] r_irq_id;

   irq_vec_t            w_irq;
   irq_vec_t            w_edge;
   irq_vec_t            w_set;
   irq_vec_t            w_clr;
   irq_vec_t            w_ack_vec;
   irq_vec_t            w_req;
   irq_vec_t            w_wdata;
   logic [2:0]          w_idx;
   logic                w_acc;
   logic                w_wr;
   logic                w_req_valid;
   logic [ID_WIDTH-1:0] w_req_id;
   logic                w_unused;

   always_comb begin
      w_irq                = '0;
      w_irq[NUM_IRQ-1:0]   = irq_i;
   end

   assign w_idx    = PADDR[4:2];
   assign w_acc    = PSEL & PENABLE;
   assign w_wr     = w_acc & PWRITE;
   assign w_wdata  = PWDATA & VALID;
   assign w_unused = ^PADDR;

   assign w_edge = w_irq & ~r_irq_q & VALID;

   always_comb begin
      w_ack_vec = '0;
      if (irq_ack_i && (32'(irq_ack_id_i) < 32'(NUM_IRQ)))
         w_ack_vec = irq_vec_t'(1) << irq_ack_id_i;
   end

   assign w_set = w_edge | ((w_wr && w_idx == REG_ISP) ? w_wdata : '0);
   assign w_clr = w_ack_vec | ((w_wr && w_idx == REG_ICP) ? w_wdata : '0);
   assign w_req = r_ipr & r_ier;

   irq_prio_enc #(
      .WIDTH (32),
      .ID_W  (ID_WIDTH)
   ) u_prio_enc (
      .i_req   (w_req),
      .o_valid (w_req_valid),
      .o_id    (w_req_id)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_irq_q  <= '0;
         r_ier    <= '0;
         r_ipr    <= '0;
         r_irq    <= 1'b0;
         r_irq_id <= '0;
      end else begin
         r_irq_q <= w_irq;
         if (w_wr && w_idx == REG_IER) r_ier <= w_wdata;
         // Set takes precedence so an edge coinciding with a clear is never lost.
         r_ipr <= (w_set | (r_ipr & ~w_clr)) & VALID;
         r_irq <= w_req_valid;
         if (w_req_valid) r_irq_id <= w_req_id;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL) begin
         case (w_idx)
            REG_IER: PRDATA = r_ier;
            REG_IPR: PRDATA = r_ipr;
            REG_ISR: PRDATA = r_ipr & r_ier;
            default: PRDATA = '0;
         endcase
      end
   end

   assign PREADY   = 1'b1;
   assign PSLVERR  = w_acc & (w_idx > REG_ISR);
   assign irq_o    = r_irq;
   assign irq_id_o = r_irq_id;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Directed bench for apb_irq_ctrl: register map, edge/pending/ack flow, priority and async reset.
module tb_apb_irq_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] irq_i;
   logic        irq_o;
   logic [4:0]  irq_id_o;
   logic        irq_ack_i;
   logic [4:0]  irq_ack_id_i;

   int n_vec = 0;
   int n_err = 0;

   apb_irq_ctrl #(.APB_ADDR_WIDTH(12), .NUM_IRQ(32), .ID_WIDTH(5)) dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .PADDR        (PADDR),
      .PWDATA       (PWDATA),
      .PWRITE       (PWRITE),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR),
      .irq_i        (irq_i),
      .irq_o        (irq_o),
      .irq_id_o     (irq_id_o),
      .irq_ack_i    (irq_ack_i),
      .irq_ack_id_i (irq_ack_id_i)
   );

   always #5 HCLK = ~HCLK;

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      d = PRDATA;
      e = PSLVERR;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic ack(input logic [4:0] id);
      @(negedge HCLK);
      irq_ack_i = 1'b1; irq_ack_id_i = id;
      @(negedge HCLK);
      irq_ack_i = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      logic        e;
      n_vec++;
      if (PREADY !== 1'b1 || irq_o !== 1'b0 || irq_id_o !== 5'd0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got pready=%b irq=%b id=%0d prdata=%h slverr=%b want 1 0 0 0 0",
                  PREADY, irq_o, irq_id_o, PRDATA, PSLVERR);
      end
      apb_read(12'h000, d, e);
      n_vec++;
      if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL reset_ier: got %h/%b want 0/0", d, e); end
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL reset_ipr: got %h want 0", d); end
      apb_read(12'h010, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL reset_isr: got %h want 0", d); end
      apb_read(12'h018, d, e);
      n_vec++;
      if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL bad_index_read: got %h/%b want 0/1", d, e); end
      apb_write(12'h01C, 32'hFFFF_FFFF);
      apb_read(12'h000, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL bad_index_write_ier: got %h want 0", d); end
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL bad_index_write_ipr: got %h want 0", d); end
   endtask

   task automatic test_single_irq;
      logic [31:0] d;
      logic        e;
      apb_write(12'h000, 32'h3);
      @(negedge HCLK);
      irq_i[1] = 1'b1;
      @(negedge HCLK);
      irq_i[1] = 1'b0;
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL single_latency_early: got irq=%b want 0", irq_o); end
      @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin
         n_err++; $display("FAIL single_irq_out: got irq=%b id=%0d want 1 1", irq_o, irq_id_o);
      end
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h2) begin n_err++; $display("FAIL single_ipr: got %h want 2", d); end
      ack(5'd1);
      n_vec++;
      if (irq_o !== 1'b1) begin n_err++; $display("FAIL single_ack_one_edge: got irq=%b want 1", irq_o); end
      @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL single_ack_drop: got irq=%b want 0", irq_o); end
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL single_ipr_cleared: got %h want 0", d); end
   endtask

   task automatic test_priority;
      apb_write(12'h000, 32'hF);
      @(negedge HCLK);
      irq_i[3] = 1'b1; irq_i[1] = 1'b1;
      repeat (2) @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd1) begin
         n_err++; $display("FAIL prio_first: got irq=%b id=%0d want 1 1", irq_o, irq_id_o);
      end
      ack(5'd1);
      @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd3) begin
         n_err++; $display("FAIL prio_second: got irq=%b id=%0d want 1 3", irq_o, irq_id_o);
      end
      ack(5'd3);
      @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b0 || irq_id_o !== 5'd3) begin
         n_err++; $display("FAIL prio_done: got irq=%b id=%0d want 0 3", irq_o, irq_id_o);
      end
      irq_i[3] = 1'b0; irq_i[1] = 1'b0;
   endtask

   task automatic test_level_no_retrigger;
      logic [31:0] d;
      logic        e;
      @(negedge HCLK);
      irq_i[2] = 1'b1;
      repeat (10) @(negedge HCLK);
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h4) begin n_err++; $display("FAIL level_ipr: got %h want 4", d); end
      apb_write(12'h008, 32'h4);
      repeat (3) @(negedge HCLK);
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL level_no_retrigger: got %h want 0", d); end
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL level_irq_off: got irq=%b want 0", irq_o); end
      irq_i[2] = 1'b0;
   endtask

   task automatic test_set_wins;
      logic [31:0] d;
      logic        e;
      @(negedge HCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h1; PENABLE = 1'b0;
      @(negedge HCLK);
      PENABLE = 1'b1; irq_i[0] = 1'b1;
      @(negedge HCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h1) begin n_err++; $display("FAIL set_wins_ipr: got %h want 1", d); end
      ack(5'd5);
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h1) begin n_err++; $display("FAIL ack_nonpending: got %h want 1", d); end
      apb_write(12'h008, 32'h1);
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL icp_clear: got %h want 0", d); end
      irq_i[0] = 1'b0;
   endtask

   task automatic test_sw_irq_and_reset;
      logic [31:0] d;
      logic        e;
      apb_write(12'h000, 32'h0);
      apb_write(12'h00C, 32'h10);
      repeat (2) @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL isp_masked_irq: got irq=%b want 0", irq_o); end
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h10) begin n_err++; $display("FAIL isp_ipr: got %h want 10", d); end
      apb_read(12'h010, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL isp_isr_masked: got %h want 0", d); end
      apb_read(12'h00C, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL isp_reads_zero: got %h want 0", d); end
      apb_write(12'h000, 32'h10);
      repeat (2) @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd4) begin
         n_err++; $display("FAIL sw_irq_enabled: got irq=%b id=%0d want 1 4", irq_o, irq_id_o);
      end
      apb_read(12'h010, d, e);
      n_vec++;
      if (d !== 32'h10) begin n_err++; $display("FAIL sw_isr: got %h want 10", d); end
      apb_write(12'h000, 32'h0);
      repeat (2) @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b0) begin n_err++; $display("FAIL disable_drops_irq: got irq=%b want 0", irq_o); end
      apb_read(12'hFE4, d, e);
      n_vec++;
      if (d !== 32'h10) begin n_err++; $display("FAIL disable_keeps_pending_alias: got %h want 10", d); end
      apb_write(12'h000, 32'h10);
      repeat (2) @(negedge HCLK);
      n_vec++;
      if (irq_o !== 1'b1 || irq_id_o !== 5'd4) begin
         n_err++; $display("FAIL reenable_irq: got irq=%b id=%0d want 1 4", irq_o, irq_id_o);
      end
      @(negedge HCLK);
      #2 HRESET = 1'b1;
      #1;
      n_vec++;
      if (irq_o !== 1'b0 || irq_id_o !== 5'd0) begin
         n_err++; $display("FAIL async_reset: got irq=%b id=%0d want 0 0", irq_o, irq_id_o);
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      apb_read(12'h004, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_ipr: got %h want 0", d); end
      apb_read(12'h000, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_ier: got %h want 0", d); end
   endtask

   initial begin
      HRESET = 1'b1;
      PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
      irq_i = '0; irq_ack_i = 1'b0; irq_ack_id_i = '0;
      repeat (3) @(negedge HCLK);
      #1;
      test_reset_pre_release();
      HRESET = 1'b0;
      test_reset();
      test_single_irq();
      test_priority();
      test_level_no_retrigger();
      test_set_wins();
      test_sw_irq_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   task automatic test_reset_pre_release;
      n_vec++;
      if (irq_o !== 1'b0 || PREADY !== 1'b1 || PRDATA !== 32'h0) begin
         n_err++; $display("FAIL in_reset: got irq=%b pready=%b prdata=%h want 0 1 0", irq_o, PREADY, PRDATA);
      end
   endtask

endmodule
